// File: rtl/axil_stream_mailbox_pkg.sv
// Shared constants for the AXI4-lite stream mailbox: register offsets,
// STATUS bit positions, response codes and the STATUS word packer.
package axil_stream_mailbox_pkg;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_TX_FULL  = 16;
    localparam int STAT_TX_EMPTY = 17;
    localparam int STAT_RX_FULL  = 18;
    localparam int STAT_RX_EMPTY = 19;
    localparam int STAT_TX_OVF   = 24;
    localparam int STAT_RX_UDF   = 25;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [7:0] tx_count;
        logic [7:0] rx_count;
        logic       tx_full;
        logic       tx_empty;
        logic       rx_full;
        logic       rx_empty;
        logic       tx_ovf;
        logic       rx_udf;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w                = '0;
        w[7:0]           = s.tx_count;
        w[15:8]          = s.rx_count;
        w[STAT_TX_FULL]  = s.tx_full;
        w[STAT_TX_EMPTY] = s.tx_empty;
        w[STAT_RX_FULL]  = s.rx_full;
        w[STAT_RX_EMPTY] = s.rx_empty;
        w[STAT_TX_OVF]   = s.tx_ovf;
        w[STAT_RX_UDF]   = s.rx_udf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO. Full/empty are registered alongside the count
// so downstream ready signals carry no combinational path from push/pop.
module sync_fifo_fwft #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE_COUNT  = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  push_ok;
    logic                  pop_ok;

    // Acceptance uses the registered flags: a push into a full FIFO is
    // refused even if a pop frees a slot in the same cycle.
    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + ONE_COUNT;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - ONE_COUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_COUNT);
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/axil_stream_mailbox.sv
// AXI4-lite slave exposing a DATA/STATUS window that bridges bus writes into a
// TX stream FIFO and an RX stream FIFO into bus reads.
module axil_stream_mailbox
    import axil_stream_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        aclk,
    input  logic        areset_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [2:2]  awaddr,
    input  logic [2:0]  awprot,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [2:2]  araddr,
    input  logic [2:0]  arprot,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] rx_data
);

    logic        aw_set_reg;
    logic        w_set_reg;
    logic        ar_set_reg;
    logic        awaddr_reg;
    logic        araddr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        tx_ovf_reg;
    logic        rx_udf_reg;

    logic                tx_push, tx_pop, tx_full, tx_empty;
    logic                rx_push, rx_pop, rx_full, rx_empty;
    logic [DEPTH_LOG2:0] tx_count, rx_count;
    logic [31:0]         rx_head;
    logic [31:0]         status_word;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic wr_exec, rd_exec, wr_data, rd_data;
    logic tx_ovf_set, tx_ovf_clr, rx_udf_set, rx_udf_clr;
    logic unused_prot;

    assign unused_prot = ^{awprot, arprot};

    assign awready = ~aw_set_reg;
    assign wready  = ~w_set_reg;
    assign arready = ~ar_set_reg;

    assign aw_hs = awvalid & ~aw_set_reg;
    assign w_hs  = wvalid & ~w_set_reg;
    assign ar_hs = arvalid & ~ar_set_reg;
    assign b_hs  = bvalid_reg & bready;
    assign r_hs  = rvalid_reg & rready;

    // Each captured request executes exactly once: the response flag
    // blocks re-execution until the handshake clears the captured flags.
    assign wr_exec = aw_set_reg & w_set_reg & ~bvalid_reg;
    assign rd_exec = ar_set_reg & ~rvalid_reg;

    assign wr_data    = wr_exec & (awaddr_reg == ADDR_DATA) & (wstrb_reg != 4'h0);
    assign tx_push    = wr_data & ~tx_full;
    assign tx_ovf_set = wr_data & tx_full;
    assign tx_ovf_clr = wr_exec & (awaddr_reg == ADDR_STATUS) & wdata_reg[STAT_TX_OVF];
    assign rx_udf_clr = wr_exec & (awaddr_reg == ADDR_STATUS) & wdata_reg[STAT_RX_UDF];

    assign rd_data    = rd_exec & (araddr_reg == ADDR_DATA);
    assign rx_pop     = rd_data & ~rx_empty;
    assign rx_udf_set = rd_data & rx_empty;

    assign tx_pop  = ~tx_empty & tx_ready;
    assign rx_push = rx_valid & ~rx_full;

    // Snapshot of registered state; same-cycle pushes/pops are not yet visible.
    assign status_word = pack_status('{
        tx_count: 8'(tx_count),
        rx_count: 8'(rx_count),
        tx_full:  tx_full,
        tx_empty: tx_empty,
        rx_full:  rx_full,
        rx_empty: rx_empty,
        tx_ovf:   tx_ovf_reg,
        rx_udf:   rx_udf_reg
    });

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_set_reg <= 1'b0;
            w_set_reg  <= 1'b0;
            awaddr_reg <= 1'b0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_set_reg <= 1'b1;
                awaddr_reg <= awaddr[2];
            end
            if (w_hs) begin
                w_set_reg <= 1'b1;
                wdata_reg <= wdata;
                wstrb_reg <= wstrb;
            end
            if (wr_exec) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= tx_ovf_set ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                bvalid_reg <= 1'b0;
                aw_set_reg <= 1'b0;
                w_set_reg  <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            ar_set_reg <= 1'b0;
            araddr_reg <= 1'b0;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                ar_set_reg <= 1'b1;
                araddr_reg <= araddr[2];
            end
            if (rd_exec) begin
                rvalid_reg <= 1'b1;
                if (araddr_reg == ADDR_STATUS) begin
                    rdata_reg <= status_word;
                    rresp_reg <= RESP_OKAY;
                end else if (!rx_empty) begin
                    rdata_reg <= rx_head;
                    rresp_reg <= RESP_OKAY;
                end else begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_SLVERR;
                end
            end else if (r_hs) begin
                rvalid_reg <= 1'b0;
                ar_set_reg <= 1'b0;
            end
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            tx_ovf_reg <= 1'b0;
            rx_udf_reg <= 1'b0;
        end else begin
            tx_ovf_reg <= tx_ovf_set | (tx_ovf_reg & ~tx_ovf_clr);
            rx_udf_reg <= rx_udf_set | (rx_udf_reg & ~rx_udf_clr);
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk   (aclk),
        .rst_n (areset_n),
        .push  (tx_push),
        .din   (wdata_reg),
        .pop   (tx_pop),
        .dout  (tx_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo_fwft #(
        .WIDTH      (32),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk   (aclk),
        .rst_n (areset_n),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign bvalid   = bvalid_reg;
    assign bresp    = bresp_reg;
    assign rvalid   = rvalid_reg;
    assign rdata    = rdata_reg;
    assign rresp    = rresp_reg;
    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

endmodule

// File: tb/tb_axil_stream_mailbox.sv
// Directed bench for axil_stream_mailbox: two instances (depth 16 and depth 2)
// share all inputs; sel picks which instance's outputs the tasks observe.
module tb_axil_stream_mailbox;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic [2:2]  awaddr = 1'b0, araddr = 1'b0;
    logic [2:0]  awprot = 3'b0, arprot = 3'b0;
    logic [31:0] wdata = '0, rx_data = '0;
    logic [3:0]  wstrb = '0;
    logic        bready = 1'b1, rready = 1'b1;
    logic        tx_ready = 1'b0, rx_valid = 1'b0;
    logic        sel = 1'b0;

    logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a, tx_valid_a, rx_ready_a;
    logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, tx_valid_b, rx_ready_b;
    logic [1:0]  bresp_a, rresp_a, bresp_b, rresp_b;
    logic [31:0] rdata_a, tx_data_a, rdata_b, tx_data_b;

    logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m, tx_valid_m, rx_ready_m;
    logic [1:0]  bresp_m, rresp_m;
    logic [31:0] rdata_m, tx_data_m;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    axil_stream_mailbox #(.DEPTH_LOG2(4)) dut_a (
        .aclk(aclk), .areset_n(areset_n),
        .awvalid(awvalid), .awready(awready_a), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready_a), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_a), .bready(bready), .bresp(bresp_a),
        .arvalid(arvalid), .arready(arready_a), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid_a), .rready(rready), .rdata(rdata_a), .rresp(rresp_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready), .tx_data(tx_data_a),
        .rx_valid(rx_valid), .rx_ready(rx_ready_a), .rx_data(rx_data)
    );

    axil_stream_mailbox #(.DEPTH_LOG2(1)) dut_b (
        .aclk(aclk), .areset_n(areset_n),
        .awvalid(awvalid), .awready(awready_b), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready_b), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid_b), .bready(bready), .bresp(bresp_b),
        .arvalid(arvalid), .arready(arready_b), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid_b), .rready(rready), .rdata(rdata_b), .rresp(rresp_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready), .tx_data(tx_data_b),
        .rx_valid(rx_valid), .rx_ready(rx_ready_b), .rx_data(rx_data)
    );

    assign awready_m  = sel ? awready_b  : awready_a;
    assign wready_m   = sel ? wready_b   : wready_a;
    assign bvalid_m   = sel ? bvalid_b   : bvalid_a;
    assign bresp_m    = sel ? bresp_b    : bresp_a;
    assign arready_m  = sel ? arready_b  : arready_a;
    assign rvalid_m   = sel ? rvalid_b   : rvalid_a;
    assign rdata_m    = sel ? rdata_b    : rdata_a;
    assign rresp_m    = sel ? rresp_b    : rresp_a;
    assign tx_valid_m = sel ? tx_valid_b : tx_valid_a;
    assign tx_data_m  = sel ? tx_data_b  : tx_data_a;
    assign rx_ready_m = sel ? rx_ready_b : rx_ready_a;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b0;
        repeat (2) @(negedge aclk);
        areset_n = 1'b1;
        @(negedge aclk);
    endtask

    // Starts and ends on a falling edge; lat counts falling edges from the
    // last address/data handshake to the first one showing bvalid.
    task automatic bus_write(input logic a, input logic [31:0] d, input logic [3:0] s,
                             input int w_delay, output logic [1:0] resp, output int lat);
        int  cyc;
        bit  aw_done, w_done, aw_fire, w_fire;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = (w_delay == 0);
        aw_done = 0; w_done = 0; cyc = 0; lat = -1; resp = 2'b11;
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_fire = awvalid && awready_m;
            w_fire  = wvalid && wready_m;
            @(negedge aclk);
            cyc++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid = 1'b0;  w_done = 1;  end
            if (!w_done && !wvalid && cyc >= w_delay) wvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (aw_done && w_done) begin
            lat = 1;
            while (!bvalid_m && lat < 20) begin
                @(negedge aclk);
                lat++;
            end
            if (bvalid_m) resp = bresp_m; else lat = -1;
            @(negedge aclk);
        end
        $display("wr addr=%0d data=%08h strb=%h resp=%0d lat=%0d", a, d, s, resp, lat);
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int cyc;
        araddr = a; arvalid = 1'b1; cyc = 0; lat = -1; d = 32'hDEAD_DEAD; resp = 2'b11;
        while (!arready_m && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        if (arready_m) begin
            @(negedge aclk);
            arvalid = 1'b0;
            lat = 1;
            while (!rvalid_m && lat < 20) begin
                @(negedge aclk);
                lat++;
            end
            if (rvalid_m) begin d = rdata_m; resp = rresp_m; end else lat = -1;
            @(negedge aclk);
        end
        arvalid = 1'b0;
        $display("rd addr=%0d data=%08h resp=%0d lat=%0d", a, d, resp, lat);
    endtask

    task automatic rx_push(input logic [31:0] d);
        int n;
        rx_valid = 1'b1; rx_data = d; n = 0;
        while (!rx_ready_m && n < 20) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        rx_valid = 1'b0;
        $display("rx push data=%08h wait=%0d", d, n);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; int l;
        sel = 1'b0;
        do_reset();
        total++;
        if ({awready_m, wready_m, arready_m, bvalid_m, rvalid_m, tx_valid_m, rx_ready_m} !== 7'b1110001) begin
            bad++;
            $display("FAIL reset_flags got=%b want=1110001",
                     {awready_m, wready_m, arready_m, bvalid_m, rvalid_m, tx_valid_m, rx_ready_m});
        end
        total++;
        if ({rdata_m, bresp_m, rresp_m} !== 36'h0) begin
            bad++;
            $display("FAIL reset_data got=%09h want=0", {rdata_m, bresp_m, rresp_m});
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h000A_0000 || r !== 2'b00 || l != 2) begin
            bad++;
            $display("FAIL reset_status got=%08h/%0d/%0d want=000a0000/0/2", d, r, l);
        end
    endtask

    task automatic test_write_same_cycle();
        logic [31:0] d; logic [1:0] r; int l;
        sel = 1'b0; tx_ready = 1'b0;
        do_reset();
        bus_write(1'b0, 32'hA5A5_0001, 4'hF, 0, r, l);
        total++;
        if (r !== 2'b00 || l != 2) begin
            bad++;
            $display("FAIL wr_same resp/lat got=%0d/%0d want=0/2", r, l);
        end
        total++;
        if (tx_valid_m !== 1'b1 || tx_data_m !== 32'hA5A5_0001) begin
            bad++;
            $display("FAIL wr_same tx got=%b/%08h want=1/a5a50001", tx_valid_m, tx_data_m);
        end
        bus_write(1'b0, 32'h0BAD_0BAD, 4'h0, 0, r, l);
        total++;
        if (r !== 2'b00) begin
            bad++;
            $display("FAIL wr_strb0 resp got=%0d want=0", r);
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h0008_0001) begin
            bad++;
            $display("FAIL wr_same status got=%08h want=00080001", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic [1:0] r0, r1, r2, r; int l0, l1, l2, l;
        sel = 1'b1; tx_ready = 1'b0;
        do_reset();
        bus_write(1'b0, 32'h0000_0100, 4'hF, 3, r0, l0);
        bus_write(1'b0, 32'h0000_0101, 4'hF, 3, r1, l1);
        bus_write(1'b0, 32'h0000_0102, 4'hF, 3, r2, l2);
        total++;
        if ({r0, r1, r2} !== 6'b00_00_10 || l0 != 2 || l2 != 2) begin
            bad++;
            $display("FAIL ovf resp got=%0d,%0d,%0d lat=%0d,%0d want=0,0,2 lat=2,2", r0, r1, r2, l0, l2);
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h0109_0002) begin
            bad++;
            $display("FAIL ovf status got=%08h want=01090002", d);
        end
        bus_write(1'b1, 32'h0100_0000, 4'hF, 3, r, l);
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h0009_0002) begin
            bad++;
            $display("FAIL ovf clear got=%08h want=00090002", d);
        end
        total++;
        if (tx_data_m !== 32'h0000_0100) begin
            bad++;
            $display("FAIL ovf head0 got=%08h want=00000100", tx_data_m);
        end
        tx_ready = 1'b1;
        @(negedge aclk);
        total++;
        if (tx_data_m !== 32'h0000_0101 || tx_valid_m !== 1'b1) begin
            bad++;
            $display("FAIL ovf head1 got=%08h/%b want=00000101/1", tx_data_m, tx_valid_m);
        end
        @(negedge aclk);
        tx_ready = 1'b0;
        total++;
        if (tx_valid_m !== 1'b0) begin
            bad++;
            $display("FAIL ovf drained tx_valid got=%b want=0", tx_valid_m);
        end
    endtask

    task automatic test_rx_underflow();
        logic [31:0] d0, d1, d2, d; logic [1:0] r0, r1, r2, r; int l;
        sel = 1'b0;
        do_reset();
        rx_push(32'h11);
        rx_push(32'h22);
        bus_read(1'b0, d0, r0, l);
        bus_read(1'b0, d1, r1, l);
        bus_read(1'b0, d2, r2, l);
        total++;
        if (d0 !== 32'h11 || r0 !== 2'b00 || d1 !== 32'h22 || r1 !== 2'b00) begin
            bad++;
            $display("FAIL rx_order got=%08h/%0d %08h/%0d want=11/0 22/0", d0, r0, d1, r1);
        end
        total++;
        if (d2 !== 32'h0 || r2 !== 2'b10) begin
            bad++;
            $display("FAIL rx_udf read got=%08h/%0d want=0/2", d2, r2);
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h020A_0000) begin
            bad++;
            $display("FAIL rx_udf status got=%08h want=020a0000", d);
        end
    endtask

    task automatic test_rx_full_wrap();
        logic [31:0] d, d0, d1, d2; logic [1:0] r, r0; int l;
        sel = 1'b1;
        do_reset();
        rx_push(32'hB0);
        rx_push(32'hB1);
        total++;
        if (rx_ready_m !== 1'b0) begin
            bad++;
            $display("FAIL rx_full rx_ready got=%b want=0", rx_ready_m);
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h0006_0200) begin
            bad++;
            $display("FAIL rx_full status got=%08h want=00060200", d);
        end
        rx_valid = 1'b1; rx_data = 32'hB2;
        fork
            bus_read(1'b0, d0, r0, l);
            begin
                @(negedge aclk);
                total++;
                if (rx_ready_m !== 1'b0) begin
                    bad++;
                    $display("FAIL rx_ready early got=%b want=0", rx_ready_m);
                end
                @(negedge aclk);
                total++;
                if (rx_ready_m !== 1'b1) begin
                    bad++;
                    $display("FAIL rx_ready rise got=%b want=1", rx_ready_m);
                end
                @(negedge aclk);
                rx_valid = 1'b0;
            end
        join
        bus_read(1'b0, d1, r, l);
        bus_read(1'b0, d2, r, l);
        total++;
        if (d0 !== 32'hB0 || r0 !== 2'b00 || d1 !== 32'hB1 || d2 !== 32'hB2) begin
            bad++;
            $display("FAIL rx_wrap got=%08h %08h %08h want=b0 b1 b2", d0, d1, d2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r, rw; int l, lw;
        sel = 1'b0; tx_ready = 1'b0;
        do_reset();
        bus_write(1'b0, 32'h0000_00C1, 4'hF, 0, r, l);
        fork
            bus_write(1'b0, 32'h0000_00C2, 4'hF, 0, rw, lw);
            bus_read(1'b1, d, r, l);
            begin
                @(negedge aclk);
                total++;
                if (tx_data_m !== 32'h0000_00C1) begin
                    bad++;
                    $display("FAIL b2b head before got=%08h want=000000c1", tx_data_m);
                end
                tx_ready = 1'b1;
                @(negedge aclk);
                tx_ready = 1'b0;
            end
        join
        total++;
        if (d !== 32'h0008_0001 || rw !== 2'b00) begin
            bad++;
            $display("FAIL b2b status got=%08h bresp=%0d want=00080001 bresp=0", d, rw);
        end
        total++;
        if (tx_data_m !== 32'h0000_00C2 || tx_valid_m !== 1'b1) begin
            bad++;
            $display("FAIL b2b head after got=%08h/%b want=000000c2/1", tx_data_m, tx_valid_m);
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h0008_0001) begin
            bad++;
            $display("FAIL b2b count got=%08h want=00080001", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; int l;
        sel = 1'b0; tx_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) bus_write(1'b0, 32'hE0 + i, 4'hF, 0, r, l);
        bready = 1'b0;
        awaddr = 1'b0; wdata = 32'hE3; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge aclk);
        total++;
        if (bvalid_m !== 1'b1) begin
            bad++;
            $display("FAIL mid bvalid pending got=%b want=1", bvalid_m);
        end
        #2;
        areset_n = 1'b0;
        #1;
        total++;
        if ({awready_m, wready_m, arready_m, bvalid_m, rvalid_m, tx_valid_m, rx_ready_m} !== 7'b1110001
            || rdata_m !== 32'h0 || bresp_m !== 2'b00) begin
            bad++;
            $display("FAIL mid async reset got=%b rdata=%08h bresp=%0d want=1110001/0/0",
                     {awready_m, wready_m, arready_m, bvalid_m, rvalid_m, tx_valid_m, rx_ready_m},
                     rdata_m, bresp_m);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        bready = 1'b1;
        @(negedge aclk);
        total++;
        if (tx_valid_m !== 1'b0) begin
            bad++;
            $display("FAIL mid tx_valid got=%b want=0", tx_valid_m);
        end
        bus_read(1'b1, d, r, l);
        total++;
        if (d !== 32'h000A_0000) begin
            bad++;
            $display("FAIL mid status got=%08h want=000a0000", d);
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_overflow();
        test_rx_underflow();
        test_rx_full_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
